// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives the PC, keeps one outstanding word fetch on the
// instruction request/response bus and buffers one instruction toward IF/ID.
// Control transfers from decode take effect after the branch delay slot; a flush
// overrides everything and drains any in-flight response before refetching.
//
// Handshakes: a request is transferred in a cycle where inst_req && inst_addr_ok;
// read data is consumed in a cycle where inst_data_ok is high while a request is
// outstanding; an instruction moves to IF/ID in a cycle where if_valid && id_allowin.
// inst_req and if_valid never rise together, so at most one item is in the stage.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        id_allowin,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        started;
  logic [31:0] next_pc;
  logic [31:0] next_pc_nxt;
  logic [31:0] last_pc;
  logic [31:0] pend_tgt;
  logic [31:0] pend_tgt_nxt;
  logic        pend;
  logic        pend_nxt;
  logic        discard;
  logic        discard_nxt;
  logic        valid_nxt;
  logic        capture;

  logic        addr_fire;
  logic        br_take;
  logic [31:0] br_tgt;
  logic [31:0] ds_pc;
  logic [31:0] issued_pc;

  // inst_req is held low during the reset cycle and rises on the first edge after release
  assign inst_req  = started && (state == S_REQ);
  assign inst_addr = next_pc;
  assign dbg_state = state;

  assign addr_fire = inst_req && inst_addr_ok;
  assign br_take   = br_valid && (pcsrc != 2'b00);
  assign br_tgt    = pcsrc[1] ? jump_target : branch_target;
  assign ds_pc     = br_pc + 32'd4;
  // Most recently issued address, counting an issue happening this very cycle
  assign issued_pc = addr_fire ? next_pc : last_pc;

  // PC selection: sequential, pending redirect, immediate redirect, then flush on top
  always_comb begin
    next_pc_nxt  = next_pc;
    pend_nxt     = pend;
    pend_tgt_nxt = pend_tgt;
    if (addr_fire) begin
      if (pend) begin
        next_pc_nxt = pend_tgt;
        pend_nxt    = 1'b0;
      end else begin
        next_pc_nxt = next_pc + 32'd4;
      end
    end
    if (br_take) begin
      if (issued_pc == ds_pc) begin
        // delay slot already on the bus: the next issue goes straight to the target
        next_pc_nxt = br_tgt;
        pend_nxt    = 1'b0;
      end else begin
        // delay slot still to be fetched; remember the target for the issue after it
        next_pc_nxt  = ds_pc;
        pend_nxt     = 1'b1;
        pend_tgt_nxt = br_tgt;
      end
    end
    if (flush) begin
      next_pc_nxt = flush_pc;
      pend_nxt    = 1'b0;
    end
  end

  // Fetch FSM: REQ -> WAIT -> HOLD -> REQ, with flush draining an in-flight response
  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    valid_nxt   = if_valid;
    capture     = 1'b0;
    case (state)
      S_REQ: begin
        if (addr_fire) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            capture   = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (id_allowin) begin
          valid_nxt = 1'b0;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
    if (flush) begin
      capture   = 1'b0;
      valid_nxt = 1'b0;
      if (((state == S_WAIT) && !inst_data_ok) || ((state == S_REQ) && addr_fire)) begin
        // a response is still owed by the bus: wait for it and drop it
        discard_nxt = 1'b1;
        state_nxt   = S_WAIT;
      end else begin
        // nothing in flight (or its data arrives right now and is dropped)
        discard_nxt = 1'b0;
        state_nxt   = S_REQ;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_REQ;
      started  <= 1'b0;
      next_pc  <= RESET_PC;
      last_pc  <= 32'd0;
      pend     <= 1'b0;
      pend_tgt <= 32'd0;
      discard  <= 1'b0;
      if_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      started  <= 1'b1;
      next_pc  <= next_pc_nxt;
      pend     <= pend_nxt;
      pend_tgt <= pend_tgt_nxt;
      discard  <= discard_nxt;
      if_valid <= valid_nxt;
      if (addr_fire) last_pc <= next_pc;
    end
  end

  // IF/ID buffer: PC and instruction word captured when fresh data returns
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_pc   <= 32'd0;
      if_inst <= 32'd0;
    end else if (capture) begin
      if_pc   <= last_pc;
      if_inst <= inst_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: random memory latency, random decode back-pressure,
// random control transfers and flushes, against a program-order PC model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [1:0]  ST_REQ   = 2'd0;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        br_valid;
  logic [31:0] br_pc;
  logic [1:0]  pcsrc;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        id_allowin;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [1:0]  dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .br_valid(br_valid), .br_pc(br_pc), .pcsrc(pcsrc),
    .branch_target(branch_target), .jump_target(jump_target),
    .flush(flush), .flush_pc(flush_pc), .id_allowin(id_allowin),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_acc = 0;

  // scoreboard queues: predicted issue addresses and predicted IF/ID PCs
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  // program-order model owned by the decode driver
  logic [31:0] prog_q[$];

  logic [31:0] salt;
  logic        mem_busy  = 1'b0;
  logic        mem_stall = 1'b0;
  int          mem_cnt   = 0;
  logic [31:0] mem_addr  = 32'd0;

  int          br_wait = 0;
  int          stall   = 0;
  bit          quiet   = 1'b0;
  logic [31:0] br_p, br_bt, br_jt;
  logic [1:0]  br_sel;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ salt;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF8;
    return {r[31:2], 2'b00};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pc(input logic [31:0] a);
    exp_addr_q.push_back(a);
    exp_pc_q.push_back(a);
    prog_q.push_back(a);
  endtask

  task automatic model_restart(input logic [31:0] pc);
    exp_addr_q.delete();
    exp_pc_q.delete();
    prog_q.delete();
    push_pc(pc);
  endtask

  // decode consumed instruction P: predict what follows it in program order
  task automatic accept();
    logic [31:0] p;
    int k;
    if (prog_q.size() == 0) return;
    p = prog_q.pop_front();
    n_acc++;
    if (prog_q.size() != 0) return;  // P is a delay slot; its successor is already known
    push_pc(p + 32'd4);
    k = quiet ? 0 : $urandom_range(0, 4);
    if (k != 0) begin
      br_p    = p;
      br_wait = $urandom_range(1, 4);
      br_bt   = rand_pc();
      br_jt   = rand_pc();
      case (k)
        1:       br_sel = 2'b00;
        2:       br_sel = 2'b01;
        3:       br_sel = 2'b10;
        default: br_sel = 2'b11;
      endcase
      if (br_sel != 2'b00) push_pc(br_sel[1] ? br_jt : br_bt);
    end
  endtask

  // one decode-side cycle: back-pressure, branch pulse, optional flush
  task automatic step(input bit use_flush, input bit force_flush, input logic [31:0] fpc);
    @(posedge clk); #1;
    br_valid      = 1'b0;
    flush         = 1'b0;
    br_pc         = $urandom;
    pcsrc         = 2'($urandom_range(0, 3));
    branch_target = $urandom;
    jump_target   = $urandom;
    flush_pc      = $urandom;
    if (br_wait > 0) begin
      br_wait--;
      id_allowin = 1'b0;
      if (br_wait == 0) begin
        br_valid      = 1'b1;
        br_pc         = br_p;
        pcsrc         = br_sel;
        branch_target = br_bt;
        jump_target   = br_jt;
      end
    end else if (stall > 0 && !quiet) begin
      stall--;
      id_allowin = 1'b0;
    end else begin
      id_allowin = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!quiet && $urandom_range(0, 30) == 0) stall = 5;
    end
    if (force_flush || (use_flush && $urandom_range(0, 40) == 0)) begin
      flush    = 1'b1;
      flush_pc = force_flush ? fpc : rand_pc();
      br_wait  = 0;
      model_restart(flush_pc);
    end
    @(negedge clk);
    if (if_valid && id_allowin && !flush) accept();
  endtask

  task automatic run_phase(input int ncyc, input bit use_flush);
    for (int c = 0; c < ncyc; c++) step(use_flush, 1'b0, 32'd0);
  endtask

  // step with allowin until the bus holds an unanswered request
  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!mem_busy && n < 60) begin
      step(1'b0, 1'b0, 32'd0);
      n++;
    end
    if (!mem_busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: no outstanding request within 60 cycles", name);
    end
  endtask

  // memory responder: random addr_ok delay, 1..3 cycle data return, optional stall
  initial begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    forever begin
      @(posedge clk); #1;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
      if (resetn) begin
        if (mem_busy) begin
          if (mem_cnt > 0) mem_cnt--;
          else if (!mem_stall) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_word(mem_addr);
            mem_busy     = 1'b0;
          end
        end else if (inst_req && $urandom_range(0, 2) != 0) begin
          inst_addr_ok = 1'b1;
          mem_addr     = inst_addr;
          mem_busy     = 1'b1;
          mem_cnt      = $urandom_range(0, 2);
        end
      end
    end
  end

  // monitor: compares presented requests and IF/ID outputs against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && !flush) begin
        if (inst_req) begin
          if (exp_addr_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL req_addr: got %08h expected no request", inst_addr);
          end else begin
            check32("req_addr", inst_addr, exp_addr_q[0]);
            if (inst_addr_ok) void'(exp_addr_q.pop_front());
          end
        end
        if (if_valid) begin
          check32("req_low_in_hold", {31'd0, inst_req}, 32'd0);
          if (exp_pc_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL if_pc: got %08h expected if_valid low", if_pc);
          end else begin
            check32("if_pc", if_pc, exp_pc_q[0]);
            check32("if_inst", if_inst, mem_word(exp_pc_q[0]));
            if (id_allowin) void'(exp_pc_q.pop_front());
          end
        end
      end
    end
  end

  // driver: directed phases around long random runs, then the summary
  initial begin
    salt          = $urandom;
    resetn        = 1'b0;
    br_valid      = 1'b0;
    br_pc         = 32'd0;
    pcsrc         = 2'b00;
    branch_target = 32'd0;
    jump_target   = 32'd0;
    flush         = 1'b0;
    flush_pc      = 32'd0;
    id_allowin    = 1'b0;
    br_p = 32'd0; br_bt = 32'd0; br_jt = 32'd0; br_sel = 2'b00;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_inst_req", {31'd0, inst_req}, 32'd0);
    check32("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check32("rst_if_pc", if_pc, 32'd0);
    check32("rst_if_inst", if_inst, 32'd0);
    check32("rst_state", {30'd0, dbg_state}, {30'd0, ST_REQ});
    model_restart(RESET_PC);
    @(posedge clk); #2;
    resetn = 1'b1;
    @(negedge clk);
    check32("req_low_after_release", {31'd0, inst_req}, 32'd0);

    // random fetch with branches and back-pressure
    run_phase(600, 1'b0);

    // flush while a response is outstanding: stale data must be dropped
    quiet = 1'b1;
    run_phase(8, 1'b0);
    mem_stall = 1'b1;
    wait_busy("flush_wait");
    step(1'b0, 1'b1, 32'hBFC0_0380);
    check32("flush_if_valid", {31'd0, if_valid}, 32'd0);
    mem_stall = 1'b0;
    run_phase(30, 1'b0);
    quiet = 1'b0;

    // random with flushes mixed in
    run_phase(600, 1'b1);

    // reset in the middle of an outstanding fetch, late data_ok afterwards
    quiet = 1'b1;
    run_phase(8, 1'b0);
    mem_stall = 1'b1;
    wait_busy("reset_wait");
    @(posedge clk); #2;
    resetn     = 1'b0;
    id_allowin = 1'b0;
    br_valid   = 1'b0;
    flush      = 1'b0;
    br_wait    = 0;
    @(negedge clk);
    check32("midrst_inst_req", {31'd0, inst_req}, 32'd0);
    check32("midrst_if_valid", {31'd0, if_valid}, 32'd0);
    check32("midrst_if_pc", if_pc, 32'd0);
    check32("midrst_if_inst", if_inst, 32'd0);
    @(posedge clk); #2;
    model_restart(RESET_PC);
    resetn    = 1'b1;
    mem_stall = 1'b0;
    @(negedge clk);
    check32("midrst_req_low", {31'd0, inst_req}, 32'd0);
    run_phase(30, 1'b0);

    // address wrap: FFFFFFF8, FFFFFFFC, 00000000, ...
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    run_phase(40, 1'b0);
    quiet = 1'b0;

    run_phase(500, 1'b1);

    // let outstanding work settle, then confirm forward progress
    quiet = 1'b1;
    run_phase(30, 1'b0);
    check32("progress", {31'd0, (n_acc >= 150)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
